fetch_pc_controller: RTL and testbench
======================================

// Module: fetch_pc_controller
// PURPOSE
//  Initiator side of the unified-memory instruction port. Owns PC_F and drives the memory's
//  PC_Addr, Stall_En and Flush_D inputs. Tracks PC_D/PC_Plus_4_D so they stay aligned with the
//  Instr_D word the memory registers. Merges hazard stall/flush, execute-stage redirects,
//  boot hold and halt into one consistent fetch sequence.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  first fetch address after reset
//  BOOT_CYCLES   2              cycles fetch is held after reset release (range 1..15)
// PORTS
//  CLK               in   1   clock; all state updates on posedge
//  RST               in   1   asynchronous, active-high reset
//  Stall_F           in   1   hazard unit: hold PC_F and the IF/ID state
//  Flush_D           in   1   hazard unit: kill the instruction entering decode
//  PC_Src_E          in   1   execute stage: branch taken / jump
//  PC_Target_E       in   32  redirect target, valid when PC_Src_E=1
//  Halt              in   1   ecall/ebreak retire: stop fetching
//  PC_Addr           out  32  to memory PC_Addr (= PC_F)
//  Mem_Stall_En      out  1   to memory Stall_En
//  Mem_Flush_D       out  1   to memory Flush_D (memory then emits NOP 32'h0000_0013)
//  PC_D              out  32  PC of the word currently on Instr_D
//  PC_Plus_4_D       out  32  PC_D + 4
//  Valid_D           out  1   Instr_D is a real, non-flushed instruction
//  Halted            out  1   state == HALT
//  Misaligned_Fault  out  1   sticky: redirect target with [1:0] != 0
//  Fetch_Count       out  32  instructions delivered to decode; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (async): PC_F=RESET_VECTOR, PC_D=0, PC_Plus_4_D=0, Valid_D=0, Halted=0,
//   Misaligned_Fault=0, Fetch_Count=0, state=BOOT, boot counter=0. Reset mid-operation
//   discards everything, including any pending redirect.
//  States: BOOT -> RUN -> HALT. HALT is left only by RST.
//  BOOT: PC_F held at RESET_VECTOR and Valid_D=0. The counter increments each edge; on the edge
//   where it reaches BOOT_CYCLES-1, state goes to RUN. The memory samples RESET_VECTOR on that edge.
//  Combinational outputs:
//   Mem_Flush_D  = (state!=RUN) | Flush_D | PC_Src_E | Halt
//   Mem_Stall_En = Stall_F & ~Mem_Flush_D; flush always wins, so the memory never sees both.
//  RUN, per posedge, priority high->low:
//   1 Halt: state<=HALT, PC_F held, Valid_D<=0.
//   2 PC_Src_E with PC_Target_E[1:0]!=0: Misaligned_Fault<=1, state<=HALT, PC_F held, Valid_D<=0.
//   3 PC_Src_E aligned: PC_F<=PC_Target_E, Valid_D<=0, PC_D<=0, PC_Plus_4_D<=0.
//     Overrides Stall_F. The target word is on Instr_D one edge later.
//   4 Flush_D: Valid_D<=0, PC_D<=0, PC_Plus_4_D<=0. PC_F<=PC_F+4 unless Stall_F.
//   5 Stall_F: PC_F, PC_D, PC_Plus_4_D, Valid_D all held.
//   6 normal: PC_D<=PC_F, PC_Plus_4_D<=PC_F+4, PC_F<=PC_F+4, Valid_D<=1, Fetch_Count+1.
//  Latency: the word at PC_Addr sampled on edge N is on Instr_D after N. Edge N also loads
//   PC_D<=PC_F, so PC_D always labels Instr_D.
//  Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0), with no fault.
//   Fetch_Count saturates and does not wrap.
//  HALT: PC_F frozen, Valid_D=0, Mem_Flush_D=1; all inputs ignored; Halted=1.
//  Misaligned_Fault is checked only for PC_Src_E while in RUN.
// TESTING
//  T1 reset release, BOOT_CYCLES=2 -> PC_Addr=0 for 2 cycles, Valid_D=0, Mem_Flush_D=1;
//     then PC_D=0,4,8 with Valid_D=1 and Fetch_Count=1,2,3.
//  T2 Stall_F=1 for 2 cycles with PC_F=0x10 -> PC_Addr stays 0x10, Mem_Stall_En=1,
//     PC_D/Valid_D held, Fetch_Count frozen.
//  T3 PC_Src_E=1, PC_Target_E=0x40, with Stall_F=1 -> Mem_Flush_D=1, Mem_Stall_En=0;
//     next edge PC_Addr=0x40, Valid_D=0; one edge later PC_D=0x40, Valid_D=1.
//  T4 PC_Src_E=1, PC_Target_E=0x42 -> Misaligned_Fault=1, Halted=1, PC_Addr frozen,
//     Mem_Flush_D=1; a later Stall_F/PC_Src_E has no effect until RST.
//  T5 force PC_F=32'hFFFF_FFFC and Fetch_Count=32'hFFFF_FFFE, run 3 cycles -> PC_Addr=0,4;
//     Fetch_Count stays 32'hFFFF_FFFF.
//  T6 Halt=1 in RUN, then RST pulse mid-HALT -> Halted=1 and Valid_D=0 immediately;
//     RST async clears all outputs to reset values and re-enters BOOT.

Source files
------------

// File: rtl/fetch_pc_controller.sv
// fetch_pc_controller: owns PC_F and drives the unified memory's PC_Addr/Stall_En/Flush_D,
// keeping PC_D/PC_Plus_4_D aligned with the Instr_D word the memory registers.
//   CLK, RST          clock, asynchronous active-high reset
//   Stall_F, Flush_D  hazard unit hold / kill requests
//   PC_Src_E          execute-stage redirect, target on PC_Target_E
//   Halt              stop fetching until reset
//   PC_Addr           fetch address (PC_F) to memory
//   Mem_Stall_En      memory stall enable
//   Mem_Flush_D       memory flush (memory emits a NOP)
//   PC_D, PC_Plus_4_D label of the word on Instr_D and its successor
//   Valid_D           Instr_D is a real instruction
//   Halted            controller is in HALT
//   Misaligned_Fault  sticky misaligned-redirect flag
//   Fetch_Count       saturating count of instructions delivered to decode
module fetch_pc_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BOOT_CYCLES  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall_F,
    input  logic        Flush_D,
    input  logic        PC_Src_E,
    input  logic [31:0] PC_Target_E,
    input  logic        Halt,
    output logic [31:0] PC_Addr,
    output logic        Mem_Stall_En,
    output logic        Mem_Flush_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC_Plus_4_D,
    output logic        Valid_D,
    output logic        Halted,
    output logic        Misaligned_Fault,
    output logic [31:0] Fetch_Count
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t      state, state_n;
    logic [3:0]  boot_cnt, boot_cnt_n;
    logic [31:0] pc_f_n, pc_d_n, pc4_d_n, count_n, pc_inc;
    logic        valid_n, fault_n, boot_done;
    assign pc_inc       = PC_Addr + 32'd4;
    // Leave BOOT on the edge where the counter reaches BOOT_CYCLES-1 (at least one edge).
    assign boot_done    = int'(boot_cnt) + 1 >= BOOT_CYCLES - 1;
    assign Mem_Flush_D  = (state != RUN) | Flush_D | PC_Src_E | Halt;
    // Flush wins so the memory never sees stall and flush together.
    assign Mem_Stall_En = Stall_F & ~Mem_Flush_D;
    assign Halted       = state == HALT;
    always_comb begin
        state_n    = state;
        boot_cnt_n = boot_cnt;
        pc_f_n     = PC_Addr;
        pc_d_n     = PC_D;
        pc4_d_n    = PC_Plus_4_D;
        valid_n    = Valid_D;
        fault_n    = Misaligned_Fault;
        count_n    = Fetch_Count;
        case (state)
            BOOT: begin
                boot_cnt_n = boot_cnt + 4'd1;
                valid_n    = 1'b0;
                state_n    = boot_done ? RUN : BOOT;
            end
            RUN: begin
                if (Halt) begin
                    state_n = HALT;
                    valid_n = 1'b0;
                end else if (PC_Src_E && PC_Target_E[1:0] != 2'b00) begin
                    fault_n = 1'b1;
                    state_n = HALT;
                    valid_n = 1'b0;
                end else if (PC_Src_E) begin
                    pc_f_n  = PC_Target_E;
                    valid_n = 1'b0;
                    pc_d_n  = '0;
                    pc4_d_n = '0;
                end else if (Flush_D) begin
                    pc_f_n  = Stall_F ? PC_Addr : pc_inc;
                    valid_n = 1'b0;
                    pc_d_n  = '0;
                    pc4_d_n = '0;
                end else if (!Stall_F) begin
                    pc_d_n  = PC_Addr;
                    pc4_d_n = pc_inc;
                    pc_f_n  = pc_inc;
                    valid_n = 1'b1;
                    count_n = (Fetch_Count == 32'hFFFF_FFFF) ? Fetch_Count : Fetch_Count + 32'd1;
                end
            end
            default: valid_n = 1'b0;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state            <= BOOT;
            boot_cnt         <= '0;
            PC_Addr          <= RESET_VECTOR;
            PC_D             <= '0;
            PC_Plus_4_D      <= '0;
            Valid_D          <= 1'b0;
            Misaligned_Fault <= 1'b0;
            Fetch_Count      <= '0;
        end else begin
            state            <= state_n;
            boot_cnt         <= boot_cnt_n;
            PC_Addr          <= pc_f_n;
            PC_D             <= pc_d_n;
            PC_Plus_4_D      <= pc4_d_n;
            Valid_D          <= valid_n;
            Misaligned_Fault <= fault_n;
            Fetch_Count      <= count_n;
        end
    end
endmodule

// File: tb/tb_fetch_pc_controller.sv
// tb_fetch_pc_controller: directed checks of boot, stall, redirect, flush, wrap, fault and halt.
module tb_fetch_pc_controller;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        Stall_F = 0, Flush_D = 0, PC_Src_E = 0, Halt = 0;
    logic [31:0] PC_Target_E = '0;
    logic [31:0] PC_Addr, PC_D, PC_Plus_4_D, Fetch_Count;
    logic        Mem_Stall_En, Mem_Flush_D, Valid_D, Halted, Misaligned_Fault;
    int          total = 0, bad = 0;

    fetch_pc_controller dut (
        .CLK(CLK), .RST(RST), .Stall_F(Stall_F), .Flush_D(Flush_D), .PC_Src_E(PC_Src_E),
        .PC_Target_E(PC_Target_E), .Halt(Halt), .PC_Addr(PC_Addr), .Mem_Stall_En(Mem_Stall_En),
        .Mem_Flush_D(Mem_Flush_D), .PC_D(PC_D), .PC_Plus_4_D(PC_Plus_4_D), .Valid_D(Valid_D),
        .Halted(Halted), .Misaligned_Fault(Misaligned_Fault), .Fetch_Count(Fetch_Count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_run(input string tag, input logic [31:0] pa, input logic [31:0] pd,
                           input logic v, input logic [31:0] cnt);
        chk({tag, ".pc_addr"}, PC_Addr, pa);
        chk({tag, ".pc_d"}, PC_D, pd);
        chk({tag, ".pc4_d"}, PC_Plus_4_D, v ? pd + 32'd4 : PC_Plus_4_D);
        chk({tag, ".valid"}, {31'd0, Valid_D}, {31'd0, v});
        chk({tag, ".count"}, Fetch_Count, cnt);
    endtask

    initial begin
        #3;
        chk("rst.pc_addr", PC_Addr, 32'h0);
        chk("rst.valid", {31'd0, Valid_D}, 32'd0);
        chk("rst.count", Fetch_Count, 32'd0);
        chk("rst.halted", {31'd0, Halted}, 32'd0);
        chk("rst.flush", {31'd0, Mem_Flush_D}, 32'd1);
        tick();
        RST = 0;
        // T1: boot holds PC_Addr=0 for two cycles
        chk("t1.boot0.pc", PC_Addr, 32'h0);
        chk("t1.boot0.flush", {31'd0, Mem_Flush_D}, 32'd1);
        tick();
        chk("t1.boot1.pc", PC_Addr, 32'h0);
        chk("t1.boot1.valid", {31'd0, Valid_D}, 32'd0);
        chk("t1.boot1.flush", {31'd0, Mem_Flush_D}, 32'd0);
        tick(); chk_run("t1.a", 32'h4, 32'h0, 1, 1);
        tick(); chk_run("t1.b", 32'h8, 32'h4, 1, 2);
        tick(); chk_run("t1.c", 32'hC, 32'h8, 1, 3);
        tick(); chk_run("t1.d", 32'h10, 32'hC, 1, 4);
        // T2: two-cycle stall at PC_F=0x10
        Stall_F = 1; #1;
        chk("t2.stall_en", {31'd0, Mem_Stall_En}, 32'd1);
        tick(); chk_run("t2.a", 32'h10, 32'hC, 1, 4);
        tick(); chk_run("t2.b", 32'h10, 32'hC, 1, 4);
        Stall_F = 0;
        tick(); chk_run("t2.c", 32'h14, 32'h10, 1, 5);
        // T3: redirect overrides stall
        Stall_F = 1; PC_Src_E = 1; PC_Target_E = 32'h40; #1;
        chk("t3.flush", {31'd0, Mem_Flush_D}, 32'd1);
        chk("t3.stall_en", {31'd0, Mem_Stall_En}, 32'd0);
        tick(); chk_run("t3.a", 32'h40, 32'h0, 0, 5);
        chk("t3.a.pc4", PC_Plus_4_D, 32'h0);
        Stall_F = 0; PC_Src_E = 0;
        tick(); chk_run("t3.b", 32'h44, 32'h40, 1, 6);
        // decode flush without stall still advances PC_F
        Flush_D = 1;
        tick(); chk_run("fl.a", 32'h48, 32'h0, 0, 6);
        Flush_D = 0;
        tick(); chk_run("fl.b", 32'h4C, 32'h48, 1, 7);
        // T5: PC wrap and Fetch_Count saturation
        PC_Src_E = 1; PC_Target_E = 32'hFFFF_FFFC;
        tick(); chk_run("t5.a", 32'hFFFF_FFFC, 32'h0, 0, 7);
        PC_Src_E = 0;
        force dut.Fetch_Count = 32'hFFFF_FFFE;
        release dut.Fetch_Count;
        tick(); chk_run("t5.b", 32'h0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFF);
        chk("t5.b.pc4", PC_Plus_4_D, 32'h0);
        tick(); chk_run("t5.c", 32'h4, 32'h0, 1, 32'hFFFF_FFFF);
        tick(); chk_run("t5.d", 32'h8, 32'h4, 1, 32'hFFFF_FFFF);
        // T4: misaligned redirect halts with sticky fault
        PC_Src_E = 1; PC_Target_E = 32'h42;
        tick();
        chk("t4.fault", {31'd0, Misaligned_Fault}, 32'd1);
        chk("t4.halted", {31'd0, Halted}, 32'd1);
        chk("t4.pc", PC_Addr, 32'h8);
        chk("t4.valid", {31'd0, Valid_D}, 32'd0);
        Stall_F = 1; PC_Target_E = 32'h80; #1;
        chk("t4.flush", {31'd0, Mem_Flush_D}, 32'd1);
        chk("t4.stall_en", {31'd0, Mem_Stall_En}, 32'd0);
        tick();
        chk("t4.hold.pc", PC_Addr, 32'h8);
        chk("t4.hold.halted", {31'd0, Halted}, 32'd1);
        Stall_F = 0; PC_Src_E = 0;
        // T6: async reset mid-HALT, reboot, then Halt in RUN
        RST = 1; #2;
        chk("t6.rst.halted", {31'd0, Halted}, 32'd0);
        chk("t6.rst.fault", {31'd0, Misaligned_Fault}, 32'd0);
        chk("t6.rst.pc", PC_Addr, 32'h0);
        chk("t6.rst.count", Fetch_Count, 32'd0);
        chk("t6.rst.pcd", PC_D, 32'h0);
        RST = 0;
        tick(); chk_run("t6.boot", 32'h0, 32'h0, 0, 0);
        tick(); chk_run("t6.run", 32'h4, 32'h0, 1, 1);
        Halt = 1; #1;
        chk("t6.halt.flush", {31'd0, Mem_Flush_D}, 32'd1);
        tick();
        chk("t6.halted", {31'd0, Halted}, 32'd1);
        chk("t6.valid", {31'd0, Valid_D}, 32'd0);
        chk("t6.pc", PC_Addr, 32'h4);
        Halt = 0;
        tick();
        chk("t6.stay.halted", {31'd0, Halted}, 32'd1);
        chk("t6.stay.pc", PC_Addr, 32'h4);
        chk("t6.stay.count", Fetch_Count, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
